maxterm_scanner: RTL and testbench

//   Reader side of the boolean-expression interface: drives a combinational function-under-test
//   (e.g. a 3-input PoS/SoP block) through every input vector 0..2^N-1 and samples its 1-bit output.

---
 rtl/maxterm_scanner_if.sv | 12 +
 rtl/maxterm_scanner.sv | 127 ++++++++++++
 tb/tb_maxterm_scanner.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/maxterm_scanner_if.sv
// Term-index stream between maxterm_scanner (master) and its consumer (slave).
// Carries a valid/ready handshake plus the N-bit term index.
interface maxterm_scanner_if #(
  parameter int unsigned N = 3
) ();
  logic         mt_valid;
  logic [N-1:0] mt_idx;
  logic         mt_ready;

  modport master (output mt_valid, output mt_idx, input mt_ready);
  modport slave  (input mt_valid, input mt_idx, output mt_ready);
endinterface

// File: rtl/maxterm_scanner.sv
// Truth-table extractor: sweeps a combinational function through all 2^N inputs, then streams
// its maxterm indices (minterm indices when MINTERM_EN is defined) over a valid/ready port.
module maxterm_scanner #(
  parameter int unsigned N      = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  output logic [N-1:0]        xyz_o,
  input  logic                s_in_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [(2**N)-1:0]   truth_o,
  output logic [N:0]          mt_count_o,
  maxterm_scanner_if.master   mt_if
);

  localparam int unsigned NumVec = 2 ** N;
  localparam int unsigned CntW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N-1:0]    LastVec  = {N{1'b1}};
  localparam logic [CntW-1:0] CntLast  = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        xyz_q, xyz_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumVec-1:0]   truth_q, truth_d;
  logic [N-1:0]        ptr_q, ptr_d;
  logic [N:0]          count_q, count_d;

  logic cnt_last;
  logic term_hit;
  logic valid;

  assign cnt_last = (cnt_q == CntLast);

`ifdef MINTERM_EN
  assign term_hit = truth_q[ptr_q];
`else
  assign term_hit = ~truth_q[ptr_q];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      xyz_q   <= '0;
      cnt_q   <= '0;
      truth_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      xyz_q   <= xyz_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xyz_d   = xyz_q;
    cnt_d   = cnt_q;
    truth_d = truth_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StScan;
          xyz_d   = '0;
          cnt_d   = '0;
          truth_d = '0;
          count_d = '0;
        end
      end
      StScan: begin
        if (cnt_last) begin
          truth_d[xyz_q] = s_in_i;
          cnt_d          = '0;
          // Last vector stays on xyz so the function input does not wrap during emit.
          if (xyz_q == LastVec) begin
            state_d = StEmit;
            ptr_d   = '0;
          end else begin
            xyz_d = xyz_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEmit: begin
        if (!term_hit || mt_if.mt_ready) begin
          if (term_hit) begin
            count_d = count_q + 1'b1;
          end
          if (ptr_q == LastVec) begin
            state_d = StDone;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    valid          = (state_q == StEmit) && term_hit;
    mt_if.mt_valid = valid;
    mt_if.mt_idx   = valid ? ptr_q : '0;
    busy_o         = (state_q == StScan) || (state_q == StEmit);
    done_o         = (state_q == StDone);
    xyz_o          = xyz_q;
    truth_o        = truth_q;
    mt_count_o     = count_q;
  end

endmodule

// File: tb/tb_maxterm_scanner.sv
// Scoreboard bench for maxterm_scanner: expected term indices are queued at stimulus time and
// popped by an independent monitor on every valid&ready handshake.
module tb_maxterm_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       ready = 1'b1;
  logic [2:0] xyz, xyz2;
  logic       s_in, s_in2;
  logic       busy, busy2, done, done2;
  logic [7:0] truth, truth2;
  logic [3:0] cnt, cnt2;
  int         fsel = 0;

  int n_vec = 0;
  int n_err = 0;
  int unsigned exp_q[$];

  maxterm_scanner_if #(.N(3)) mif ();
  maxterm_scanner_if #(.N(3)) mif2 ();

  assign mif.mt_ready  = ready;
  assign mif2.mt_ready = 1'b1;

  always #5 clk = ~clk;

  function automatic logic f_eval(input int sel, input logic [2:0] v);
    case (sel)
      0:       return (v < 3'd5);  // maxterms 5,6,7
      1:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign s_in  = f_eval(fsel, xyz);
  assign s_in2 = f_eval(0, xyz2);

  maxterm_scanner #(.N(3), .SETTLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .xyz_o      (xyz),
    .s_in_i     (s_in),
    .busy_o     (busy),
    .done_o     (done),
    .truth_o    (truth),
    .mt_count_o (cnt),
    .mt_if      (mif)
  );

  maxterm_scanner #(.N(3), .SETTLE(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start2),
    .xyz_o      (xyz2),
    .s_in_i     (s_in2),
    .busy_o     (busy2),
    .done_o     (done2),
    .truth_o    (truth2),
    .mt_count_o (cnt2),
    .mt_if      (mif2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on handshake and checks that a stalled term stays put.
  logic       stall_q = 1'b0;
  logic [2:0] stall_idx = '0;
  always @(negedge clk) begin
    if (!rst && stall_q) begin
      chk("stall_hold_valid", 64'(mif.mt_valid), 64'd1);
      chk("stall_hold_idx", 64'(mif.mt_idx), 64'(stall_idx));
    end
    if (!rst && mif.mt_valid && mif.mt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_term", 64'(mif.mt_idx), 64'hDEAD);
      end else begin
        chk("term_idx", 64'(mif.mt_idx), 64'(exp_q.pop_front()));
      end
    end
    stall_q   <= !rst && mif.mt_valid && !mif.mt_ready;
    stall_idx <= mif.mt_idx;
  end

  task automatic run_scan(input int sel, input bit stall, input logic [7:0] exp_truth,
                          input logic [3:0] exp_cnt);
    bit got;
    int unsigned first;
    fsel = sel;
    for (int p = 0; p < 8; p++) begin
`ifdef MINTERM_EN
      if (exp_truth[p]) exp_q.push_back(p);
`else
      if (!exp_truth[p]) exp_q.push_back(p);
`endif
    end
    first = (exp_q.size() != 0) ? exp_q[0] : 0;
    ready = !stall;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("xyz_after_start", 64'(xyz), 64'd0);
    chk("truth_cleared", 64'(truth), 64'd0);
    if (stall) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        if (mif.mt_valid) got = 1'b1;
      end
      chk("stall_valid_seen", 64'(got), 64'd1);
      chk("stall_idx_c1", 64'(mif.mt_idx), 64'(first));
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk("stall_valid", 64'(mif.mt_valid), 64'd1);
        chk("stall_idx", 64'(mif.mt_idx), 64'(first));
      end
      @(posedge clk); #1 ready = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("valid_at_done", 64'(mif.mt_valid), 64'd0);
    chk("truth", 64'(truth), 64'(exp_truth));
    chk("mt_count", 64'(cnt), 64'(exp_cnt));
    chk("terms_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("truth_held", 64'(truth), 64'(exp_truth));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    #12;
    chk("rst_xyz", 64'(xyz), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_truth", 64'(truth), 64'd0);
    chk("rst_valid", 64'(mif.mt_valid), 64'd0);
    chk("rst_idx", 64'(mif.mt_idx), 64'd0);
    chk("rst_count", 64'(cnt), 64'd0);
    #11 rst = 1'b0;

`ifdef MINTERM_EN
    run_scan(0, 1'b0, 8'h1F, 4'd5);
    run_scan(0, 1'b1, 8'h1F, 4'd5);
    run_scan(1, 1'b0, 8'h00, 4'd0);
    run_scan(2, 1'b0, 8'hFF, 4'd8);
`else
    run_scan(0, 1'b0, 8'h1F, 4'd3);
    run_scan(0, 1'b1, 8'h1F, 4'd3);
    run_scan(1, 1'b0, 8'h00, 4'd8);
    run_scan(2, 1'b0, 8'hFF, 4'd0);
`endif

    // Reset in the middle of a scan.
    fsel  = 0;
    ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (xyz == 3'd3) got = 1'b1;
    end
    chk("reach_xyz3", 64'(got), 64'd1);
    chk("partial_truth", 64'(truth), 64'h07);
    rst = 1'b1;
    #1;
    chk("midrst_xyz", 64'(xyz), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_truth", 64'(truth), 64'd0);
    chk("midrst_count", 64'(cnt), 64'd0);
    #2 rst = 1'b0;
`ifdef MINTERM_EN
    run_scan(0, 1'b0, 8'h1F, 4'd5);
`else
    run_scan(0, 1'b0, 8'h1F, 4'd3);
`endif

    // SETTLE=2 instance: xyz steps every two cycles; start during scan is ignored.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("s2_xyz", 64'(xyz2), 64'(i / 2));
      chk("s2_busy", 64'(busy2), 64'd1);
      if (i == 4) start2 = 1'b1;
      if (i == 5) start2 = 1'b0;
    end
    @(negedge clk);
    chk("s2_xyz_hold", 64'(xyz2), 64'd7);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done2) got = 1'b1;
      else @(negedge clk);
    end
    chk("s2_done_seen", 64'(got), 64'd1);
    chk("s2_truth", 64'(truth2), 64'h1F);
`ifdef MINTERM_EN
    chk("s2_count", 64'(cnt2), 64'd5);
`else
    chk("s2_count", 64'(cnt2), 64'd3);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("s2_no_retrigger", 64'(busy2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
